// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Opcode constants, FSM state type and width defaults shared by
//               the ALU round-robin scheduler and its op unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_SEL_W  = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_op_unit.sv
// ============================================================================
// Module      : alu_op_unit
// Description : Combinational ALU op unit; unknown opcodes give zero and err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_unit
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEL_W  = DEF_SEL_W
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [SEL_W-1:0]  i_sel,
    output logic [DATA_W-1:0] o_result,
    output logic              o_err
);

    // Add/sub wrap naturally because the result is truncated to DATA_W.
    always_comb begin
        o_result = '0;
        o_err    = 1'b0;
        if (i_sel == SEL_W'(OP_ADD)) begin
            o_result = i_a + i_b;
        end else if (i_sel == SEL_W'(OP_SUB)) begin
            o_result = i_a - i_b;
        end else if (i_sel == SEL_W'(OP_AND)) begin
            o_result = i_a & i_b;
        end else if (i_sel == SEL_W'(OP_OR)) begin
            o_result = i_a | i_b;
        end else if (i_sel == SEL_W'(OP_NOT)) begin
            o_result = ~i_a;
        end else begin
            o_err = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_rr_scheduler.sv
// ============================================================================
// Module      : alu_rr_scheduler
// Description : Round-robin scheduler sharing one ALU op unit between NUM_REQ
//               requesters, one operation in flight, registered response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = DEF_DATA_W,
    parameter  int SEL_W   = DEF_SEL_W,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [ID_W-1:0]           resp_id,
    output logic [DATA_W-1:0]         resp_result,
    output logic                      resp_zero,
    output logic                      resp_err,
    output logic                      busy
);

    state_t            r_state_q,  w_state_d;
    logic [ID_W-1:0]   r_rr_ptr_q, w_rr_ptr_d;
    logic [ID_W-1:0]   r_id_q,     w_id_d;
    logic [DATA_W-1:0] r_a_q,      w_a_d;
    logic [DATA_W-1:0] r_b_q,      w_b_d;
    logic [SEL_W-1:0]  r_sel_q,    w_sel_d;
    logic [DATA_W-1:0] r_result_q, w_result_d;
    logic              r_zero_q,   w_zero_d;
    logic              r_err_q,    w_err_d;

    logic              w_found;
    logic [ID_W-1:0]   w_grant;
    logic [ID_W:0]     w_idx;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_err;

    // Scan upward from rr_ptr; the extra index bit lets non-power-of-two counts wrap explicitly.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, r_rr_ptr_q} + (ID_W+1)'(i);
            if (w_idx >= (ID_W+1)'(NUM_REQ)) begin
                w_idx = w_idx - (ID_W+1)'(NUM_REQ);
            end
            if (!w_found && req_valid[w_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((r_state_q == IDLE) && w_found && (w_grant == ID_W'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    alu_op_unit #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_op_unit (
        .i_a      (r_a_q),
        .i_b      (r_b_q),
        .i_sel    (r_sel_q),
        .o_result (w_alu_result),
        .o_err    (w_alu_err)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_rr_ptr_d = r_rr_ptr_q;
        w_id_d     = r_id_q;
        w_a_d      = r_a_q;
        w_b_d      = r_b_q;
        w_sel_d    = r_sel_q;
        w_result_d = r_result_q;
        w_zero_d   = r_zero_q;
        w_err_d    = r_err_q;
        case (r_state_q)
            IDLE: begin
                if (w_found) begin
                    w_a_d     = req_a[int'(w_grant)*DATA_W +: DATA_W];
                    w_b_d     = req_b[int'(w_grant)*DATA_W +: DATA_W];
                    w_sel_d   = req_sel[int'(w_grant)*SEL_W +: SEL_W];
                    w_id_d    = w_grant;
                    w_state_d = EXEC;
                end
            end
            EXEC: begin
                w_result_d = w_alu_result;
                w_zero_d   = (w_alu_result == '0);
                w_err_d    = w_alu_err;
                w_state_d  = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    w_rr_ptr_d = (r_id_q == ID_W'(NUM_REQ-1)) ? '0 : r_id_q + 1'b1;
                    w_state_d  = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= IDLE;
            r_rr_ptr_q <= '0;
            r_id_q     <= '0;
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_sel_q    <= '0;
            r_result_q <= '0;
            r_zero_q   <= 1'b0;
            r_err_q    <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_rr_ptr_q <= w_rr_ptr_d;
            r_id_q     <= w_id_d;
            r_a_q      <= w_a_d;
            r_b_q      <= w_b_d;
            r_sel_q    <= w_sel_d;
            r_result_q <= w_result_d;
            r_zero_q   <= w_zero_d;
            r_err_q    <= w_err_d;
        end
    end

    assign resp_valid  = (r_state_q == RESP);
    assign busy        = (r_state_q != IDLE);
    assign resp_id     = r_id_q;
    assign resp_result = r_result_q;
    assign resp_zero   = r_zero_q;
    assign resp_err    = r_err_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_rr_scheduler.sv
// ============================================================================
// Module      : tb_alu_rr_scheduler
// Description : Self-checking bench for alu_rr_scheduler: directed scenarios
//               plus randomized traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_rr_scheduler;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int SW = 3;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [N*SW-1:0] req_sel;
    logic            resp_valid;
    logic            resp_ready;
    logic [IW-1:0]   resp_id;
    logic [DW-1:0]   resp_result;
    logic            resp_zero;
    logic            resp_err;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    // Observations returned by run_op.
    logic [N-1:0]  o_rdy;
    logic          o_v1, o_v2, o_z, o_e;
    logic [IW-1:0] o_id;
    logic [DW-1:0] o_res;

    always #5 clk = ~clk;

    alu_rr_scheduler #(.NUM_REQ(N), .DATA_W(DW), .SEL_W(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_sel     (req_sel),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .resp_err    (resp_err),
        .busy        (busy)
    );

    function automatic logic [DW-1:0] model_result(input int a, input int b, input int s);
        int r;
        case (s)
            0:       r = (a + b) % 16;
            1:       r = (a - b + 16) % 16;
            2:       r = a & b;
            3:       r = a | b;
            4:       r = 15 - a;
            default: r = 0;
        endcase
        return r[DW-1:0];
    endfunction

    task automatic set_req(input int i, input int a, input int b, input int s);
        req_valid[i]          = 1'b1;
        req_a[i*DW +: DW]     = DW'(a);
        req_b[i*DW +: DW]     = DW'(b);
        req_sel[i*SW +: SW]   = SW'(s);
    endtask

    // One isolated operation with resp_ready high; caller must start from IDLE.
    task automatic run_op(input int i, input int a, input int b, input int s);
        @(negedge clk);
        set_req(i, a, b, s);
        #1 o_rdy = req_ready;
        @(negedge clk);
        req_valid[i] = 1'b0;
        #1 o_v1 = resp_valid;
        @(negedge clk);
        #1;
        o_v2  = resp_valid;
        o_id  = resp_id;
        o_res = resp_result;
        o_z   = resp_zero;
        o_e   = resp_err;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; resp_ready = 1'b1;
        req_a = '0; req_b = '0; req_sel = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%0h exp=0", resp_valid); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%0h exp=0", req_ready); end
        checks++; if ({resp_id, resp_result, resp_zero, resp_err} !== 8'h00) begin failures++;
            $display("FAIL reset_resp_fields got=%0h/%0h/%0h/%0h exp=0", resp_id, resp_result, resp_zero, resp_err); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        run_op(2, 3, 5, 0);
        checks++; if (o_rdy !== 4'b0100) begin failures++; $display("FAIL single_ready got=%0h exp=4", o_rdy); end
        checks++; if (o_v1 !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%0h exp=0", o_v1); end
        checks++; if (o_v2 !== 1'b1) begin failures++; $display("FAIL single_valid got=%0h exp=1", o_v2); end
        checks++; if (o_id !== 2'd2) begin failures++; $display("FAIL single_id got=%0h exp=2", o_id); end
        checks++; if (o_res !== 4'd8 || o_z !== 1'b0 || o_e !== 1'b0) begin failures++;
            $display("FAIL single_result got=%0h z=%0h e=%0h exp=8 z=0 e=0", o_res, o_z, o_e); end
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%0h exp=0", busy); end
    endtask

    task automatic test_wrap_sub();
        run_op(0, 2, 3, 1);
        checks++; if (o_rdy !== 4'b0001) begin failures++; $display("FAIL sub_ready got=%0h exp=1", o_rdy); end
        checks++; if (o_res !== 4'hF || o_z !== 1'b0 || o_e !== 1'b0) begin failures++;
            $display("FAIL sub_result got=%0h z=%0h e=%0h exp=f z=0 e=0", o_res, o_z, o_e); end
        run_op(0, 15, 1, 0);
        checks++; if (o_res !== 4'h0 || o_z !== 1'b1 || o_e !== 1'b0) begin failures++;
            $display("FAIL add_wrap_result got=%0h z=%0h e=%0h exp=0 z=1 e=0", o_res, o_z, o_e); end
    endtask

    task automatic test_round_robin();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, i + 1, i, 0);
        for (int c = 0; c < 15; c++) begin
            logic [N-1:0] exp_rdy;
            int k;
            k = (c / 3) % N;
            exp_rdy = '0;
            if (c % 3 == 0) exp_rdy[k] = 1'b1;
            #1;
            checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rr_ready cyc=%0d got=%0h exp=%0h", c, req_ready, exp_rdy); end
            if (c % 3 == 2) begin
                checks++; if (resp_valid !== 1'b1 || resp_id !== IW'(k) || resp_result !== DW'(2*k + 1)) begin failures++;
                    $display("FAIL rr_resp cyc=%0d got v=%0h id=%0h res=%0h exp v=1 id=%0h res=%0h", c, resp_valid, resp_id, resp_result, k, 2*k+1); end
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        // Pointer is 1 after the round-robin run.
        set_req(1, 6, 7, 3);
        resp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_accept got=%0h exp=2", req_ready); end
        @(negedge clk);
        req_valid[1] = 1'b0;
        set_req(3, 4, 4, 0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_result !== 4'd7 || req_ready !== 4'b0000) begin failures++;
                $display("FAIL bp_hold cyc=%0d got v=%0h id=%0h res=%0h rdy=%0h exp v=1 id=1 res=7 rdy=0", c, resp_valid, resp_id, resp_result, req_ready); end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b1000 || resp_valid !== 1'b0) begin failures++;
            $display("FAIL bp_release got rdy=%0h v=%0h exp rdy=8 v=0", req_ready, resp_valid); end
        @(negedge clk);
        req_valid[3] = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_result !== 4'd8) begin failures++;
            $display("FAIL bp_next_resp got v=%0h id=%0h res=%0h exp v=1 id=3 res=8", resp_valid, resp_id, resp_result); end
    endtask

    task automatic test_illegal_not();
        run_op(0, 9, 6, 7);
        checks++; if (o_res !== 4'h0 || o_z !== 1'b1 || o_e !== 1'b1) begin failures++;
            $display("FAIL illegal_op got=%0h z=%0h e=%0h exp=0 z=1 e=1", o_res, o_z, o_e); end
        run_op(1, 5, 0, 4);
        checks++; if (o_res !== 4'hA || o_z !== 1'b0 || o_e !== 1'b0) begin failures++;
            $display("FAIL not_op got=%0h z=%0h e=%0h exp=a z=0 e=0", o_res, o_z, o_e); end
    endtask

    task automatic test_reset_mid();
        // Pointer is 2 here, so a grant of 0 afterwards proves it was cleared.
        @(negedge clk);
        set_req(3, 1, 1, 0);
        #1;
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL rstmid_accept got=%0h exp=8", req_ready); end
        @(negedge clk);
        req_valid[3] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || resp_valid !== 1'b0 || resp_id !== 2'd0 || resp_result !== 4'd0) begin failures++;
            $display("FAIL rstmid_cleared got busy=%0h v=%0h id=%0h res=%0h exp all 0", busy, resp_valid, resp_id, resp_result); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_no_resp cyc=%0d got=%0h exp=0", c, resp_valid); end
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) set_req(i, 2, 2, 0);
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rstmid_ptr got=%0h exp=1", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_result !== 4'd4) begin failures++;
            $display("FAIL rstmid_next got v=%0h id=%0h res=%0h exp v=1 id=0 res=4", resp_valid, resp_id, resp_result); end
    endtask

    task automatic test_random();
        bit pend[N];
        int pa[N], pb[N], ps[N];
        int phase, ptr, g, eid, eres, ez, ee;
        logic [N-1:0] exp_rdy;
        @(negedge clk); rst = 1'b1; req_valid = '0;
        @(negedge clk); rst = 1'b0;
        phase = 0; ptr = 0; eid = 0; eres = 0; ez = 0; ee = 0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    pa[i] = $urandom_range(0, 15);
                    pb[i] = $urandom_range(0, 15);
                    ps[i] = $urandom_range(0, 7);
                    set_req(i, pa[i], pb[i], ps[i]);
                end else if (!pend[i]) begin
                    req_valid[i] = 1'b0;
                    req_a[i*DW +: DW] = DW'($urandom);
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = -1;
            if (phase == 0) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && pend[(ptr + k) % N]) g = (ptr + k) % N;
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            checks++; if (req_ready !== exp_rdy || busy !== (phase != 0) || resp_valid !== (phase == 2)) begin failures++;
                $display("FAIL rand_ctrl cyc=%0d got rdy=%0h busy=%0h v=%0h exp rdy=%0h busy=%0h v=%0h",
                         c, req_ready, busy, resp_valid, exp_rdy, phase != 0, phase == 2); end
            if (phase == 2) begin
                checks++; if (resp_id !== IW'(eid) || resp_result !== DW'(eres) || resp_zero !== ez[0] || resp_err !== ee[0]) begin failures++;
                    $display("FAIL rand_resp cyc=%0d got id=%0h res=%0h z=%0h e=%0h exp id=%0h res=%0h z=%0h e=%0h",
                             c, resp_id, resp_result, resp_zero, resp_err, eid, eres, ez, ee); end
            end
            case (phase)
                0: if (g >= 0) begin
                    eid  = g;
                    eres = int'(model_result(pa[g], pb[g], ps[g]));
                    ez   = (eres == 0) ? 1 : 0;
                    ee   = (ps[g] > 4) ? 1 : 0;
                    pend[g] = 1'b0;
                    phase = 1;
                end
                1: phase = 2;
                default: if (resp_ready) begin
                    ptr = (eid + 1) % N;
                    phase = 0;
                end
            endcase
            @(negedge clk);
        end
        req_valid = '0;
        resp_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        resp_ready = 1'b1;
        req_a = '0; req_b = '0; req_sel = '0;
        test_reset();
        test_single();
        test_wrap_sub();
        test_round_robin();
        test_backpressure();
        test_illegal_not();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
